coherence_bus_arbiter: RTL and testbench

- Shared snoop-bus controller for the three private L1 caches and the common L2.
- Accepts coherence transactions from each L1 controller: BusRd on read miss, BusRdX on write miss, BusUpgr on write hit to a Shared line, WriteBack on eviction of a Modified line.
- Grants the bus round-robin and broadcasts each transaction as a snoop to the other caches.
- Sequences any dirty flush and the L2 read/write, then returns completion and shared status to the requester.

---
 rtl/coherence_bus_arbiter_if.sv | 48 ++++
 rtl/coherence_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_arbiter_if.sv
// Coherence bus interface: groups the L1 request/grant handshake, the snoop
// broadcast with its per-cache responses, and the L2 access handshake.
//   master : the arbiter side (drives grants, snoops and L2 requests)
//   slave  : the caches / L2 side (drives requests, snoop responses, l2_done)
// Signals:
//   req/req_op/req_addr        per-cache transaction request, op and line address
//   gnt/done/shared_out        one-hot grant, completion pulse, shared status
//   snoop_valid/op/addr/src    snoop broadcast; cache snoop_src ignores it
//   snoop_ack/shared/dirty     per-cache snoop response
//   l2_rd_en/l2_wr_en/l2_addr  L2 request (level), l2_done completes it
interface coherence_bus_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [2*N_REQ-1:0]      req_op;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic                    shared_out;

  logic                    snoop_valid;
  logic [1:0]              snoop_op;
  logic [ADDR_W-1:0]       snoop_addr;
  logic [SRC_W-1:0]        snoop_src;
  logic [N_REQ-1:0]        snoop_ack;
  logic [N_REQ-1:0]        snoop_shared;
  logic [N_REQ-1:0]        snoop_dirty;

  logic                    l2_rd_en;
  logic                    l2_wr_en;
  logic [ADDR_W-1:0]       l2_addr;
  logic                    l2_done;

  modport master (
    input  req, req_op, req_addr, snoop_ack, snoop_shared, snoop_dirty, l2_done,
    output gnt, done, shared_out, snoop_valid, snoop_op, snoop_addr, snoop_src,
           l2_rd_en, l2_wr_en, l2_addr
  );

  modport slave (
    output req, req_op, req_addr, snoop_ack, snoop_shared, snoop_dirty, l2_done,
    input  gnt, done, shared_out, snoop_valid, snoop_op, snoop_addr, snoop_src,
           l2_rd_en, l2_wr_en, l2_addr
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Shared snoop-bus controller for N_REQ private L1 caches and a common L2.
// Grants the bus round-robin, broadcasts BusRd/BusRdX/BusUpgr as snoops to
// the other caches, sequences a dirty flush and the L2 read/write, then
// returns a done pulse plus shared status to the requester.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        coherence_bus_arbiter_if.master (requests, snoops, L2)
//   proto_err  sticky protocol-error flag, cleared only by reset
module coherence_bus_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  coherence_bus_arbiter_if.master bus,
  output logic                    proto_err
);
  localparam int SRC_W = $clog2(N_REQ);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_RDX  = 2'b01;
  localparam logic [1:0] OP_UPGR = 2'b10;
  localparam logic [1:0] OP_WB   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_FLUSH,
    ST_L2_ACCESS,
    ST_COMPLETE
  } state_t;

  state_t             state_reg, state_next;
  logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [SRC_W-1:0]   src_reg, src_next;
  logic [1:0]         op_reg, op_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [N_REQ-1:0]   ack_seen_reg, ack_seen_next;
  logic [N_REQ-1:0]   shared_acc_reg, shared_acc_next;
  logic [N_REQ-1:0]   dirty_acc_reg, dirty_acc_next;
  logic               proto_err_reg, proto_err_next;

  // Per-requester views of the packed op/address buses.
  logic [1:0]         op_arr   [N_REQ];
  logic [ADDR_W-1:0]  addr_arr [N_REQ];
  logic [N_REQ-1:0]   src_onehot;
  logic               busy;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_arr[gi]     = bus.req_op[2*gi +: 2];
      assign addr_arr[gi]   = bus.req_addr[ADDR_W*gi +: ADDR_W];
      assign src_onehot[gi] = (src_reg == SRC_W'(gi));
      assign bus.gnt[gi]    = busy && src_onehot[gi];
      assign bus.done[gi]   = (state_reg == ST_COMPLETE) && src_onehot[gi];
    end
  endgenerate

  // Round-robin pick: scan candidates from rr_ptr upward with wrap. The loop
  // runs from the farthest candidate back to rr_ptr so the last hit wins,
  // which is the first requester in scan order.
  logic               pick_valid;
  logic [SRC_W-1:0]   pick_idx;
  logic [SRC_W:0]     cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(N_REQ)) begin
        cand = cand - (SRC_W+1)'(N_REQ);
      end
      if (bus.req[cand[SRC_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Snoop response accumulation including this cycle's responses; the
  // owner's own lines are masked since it does not answer its own snoop.
  logic [N_REQ-1:0]   ack_now, shared_now, dirty_now;
  logic               all_acked;
  logic               snoop_err;

  always_comb begin
    ack_now    = ack_seen_reg   | (bus.snoop_ack & ~src_onehot);
    shared_now = shared_acc_reg | (bus.snoop_ack & bus.snoop_shared & ~src_onehot);
    dirty_now  = dirty_acc_reg  | (bus.snoop_ack & bus.snoop_dirty & ~src_onehot);
    all_acked  = &(ack_now | src_onehot);
    // A dirty owner must be unique and exclusive, and an upgrade or
    // writeback implies the requester already owns the line.
    snoop_err  = ((dirty_now != '0) && ((op_reg == OP_UPGR) || (op_reg == OP_WB)))
              || ((dirty_now & (dirty_now - 1'b1)) != '0)
              || ((dirty_now != '0) && ((shared_now & ~dirty_now) != '0));
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    src_next        = src_reg;
    op_next         = op_reg;
    addr_next       = addr_reg;
    ack_seen_next   = ack_seen_reg;
    shared_acc_next = shared_acc_reg;
    dirty_acc_next  = dirty_acc_reg;
    proto_err_next  = proto_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          src_next        = pick_idx;
          op_next         = op_arr[pick_idx];
          addr_next       = addr_arr[pick_idx];
          ack_seen_next   = '0;
          shared_acc_next = '0;
          dirty_acc_next  = '0;
          // Writebacks carry the only valid copy; no snoop is needed.
          state_next      = (op_arr[pick_idx] == OP_WB) ? ST_L2_ACCESS : ST_SNOOP;
        end
      end

      ST_SNOOP: begin
        ack_seen_next   = ack_now;
        shared_acc_next = shared_now;
        dirty_acc_next  = dirty_now;
        if (snoop_err) begin
          proto_err_next = 1'b1;
        end
        if (all_acked) begin
          if ((dirty_now != '0) && ((op_reg == OP_RD) || (op_reg == OP_RDX))) begin
            state_next = ST_FLUSH;
          end else if (op_reg == OP_UPGR) begin
            state_next = ST_COMPLETE;
          end else begin
            state_next = ST_L2_ACCESS;
          end
        end
      end

      ST_FLUSH: begin
        if (bus.l2_done) begin
          state_next = ST_L2_ACCESS;
        end
      end

      ST_L2_ACCESS: begin
        if (bus.l2_done) begin
          state_next = ST_COMPLETE;
        end
      end

      ST_COMPLETE: begin
        rr_ptr_next = (src_reg == SRC_W'(N_REQ - 1)) ? '0 : src_reg + 1'b1;
        state_next  = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= '0;
      src_reg        <= '0;
      op_reg         <= '0;
      addr_reg       <= '0;
      ack_seen_reg   <= '0;
      shared_acc_reg <= '0;
      dirty_acc_reg  <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      src_reg        <= src_next;
      op_reg         <= op_next;
      addr_reg       <= addr_next;
      ack_seen_reg   <= ack_seen_next;
      shared_acc_reg <= shared_acc_next;
      dirty_acc_reg  <= dirty_acc_next;
      proto_err_reg  <= proto_err_next;
    end
  end

  assign busy            = (state_reg != ST_IDLE);
  assign bus.snoop_valid = (state_reg == ST_SNOOP);
  assign bus.snoop_op    = op_reg;
  assign bus.snoop_addr  = addr_reg;
  assign bus.snoop_src   = src_reg;
  assign bus.shared_out  = (state_reg == ST_COMPLETE) && (op_reg == OP_RD) && (shared_acc_reg != '0);
  assign bus.l2_wr_en    = (state_reg == ST_FLUSH) || ((state_reg == ST_L2_ACCESS) && (op_reg == OP_WB));
  assign bus.l2_rd_en    = (state_reg == ST_L2_ACCESS) && (op_reg != OP_WB);
  assign bus.l2_addr     = addr_reg;
  assign proto_err       = proto_err_reg;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
`timescale 1ns/1ps
module tb_coherence_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic proto_err;

  always #5 clk = ~clk;

  coherence_bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

  coherence_bus_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .proto_err (proto_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder configuration (cache snoop behaviour and L2 latency).
  int ack_dly [N];
  bit shr     [N];
  bit drt     [N];
  int l2_lat   = 0;
  bit stray_en = 1'b0;

  task automatic cfg_clear();
    for (int i = 0; i < N; i++) begin
      ack_dly[i] = 0;
      shr[i]     = 1'b0;
      drt[i]     = 1'b0;
    end
    l2_lat   = 0;
    stray_en = 1'b0;
  endtask

  // Scoreboards.
  typedef struct {
    int             src;
    int             op;
    logic [AW-1:0]  addr;
    int             shared;
    int             lat;
  } txn_t;

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
  } l2_t;

  txn_t sb  [$];
  l2_t  l2q [$];

  int cyc        = 0;
  int last_done  = 0;
  bit b2b_check  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: latency from grant to done = snoop cycles + flush + L2 access.
  task automatic expect_txn(input int src, input int op, input logic [AW-1:0] addr);
    txn_t t;
    l2_t  a;
    int   s_cyc = 0;
    bit   dirty = 1'b0;
    bit   shd   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i != src) begin
        if (ack_dly[i] + 1 > s_cyc) s_cyc = ack_dly[i] + 1;
        dirty |= drt[i];
        shd   |= shr[i];
      end
    end
    t.src    = src;
    t.op     = op;
    t.addr   = addr;
    t.shared = (op == 0 && shd) ? 1 : 0;
    t.lat    = (op == 3) ? 0 : s_cyc;
    if (op <= 1 && dirty) begin
      t.lat += l2_lat + 1;
      a.wr = 1'b1; a.addr = addr;
      l2q.push_back(a);
    end
    if (op != 2) begin
      t.lat += l2_lat + 1;
      a.wr = (op == 3); a.addr = addr;
      l2q.push_back(a);
    end
    sb.push_back(t);
  endtask

  // Cache and L2 responder.
  initial begin : responder
    int scnt = 0;
    int lcnt = 0;
    logic [1:0] lkind_prev = 2'b00;
    logic [1:0] lkind;
    forever begin
      @(negedge clk);
      bus.snoop_ack    = '0;
      bus.snoop_shared = '0;
      bus.snoop_dirty  = '0;
      bus.l2_done      = 1'b0;
      if (rst_n && bus.snoop_valid) begin
        for (int i = 0; i < N; i++) begin
          if (i != int'(bus.snoop_src) && scnt >= ack_dly[i]) begin
            bus.snoop_ack[i]    = 1'b1;
            bus.snoop_shared[i] = shr[i];
            bus.snoop_dirty[i]  = drt[i];
          end
        end
        if (stray_en && scnt == 1) bus.l2_done = 1'b1;
        scnt++;
      end else begin
        scnt = 0;
      end
      lkind = {bus.l2_rd_en, bus.l2_wr_en};
      if (!rst_n || lkind == 2'b00 || lkind != lkind_prev) lcnt = 0;
      if (rst_n && lkind != 2'b00) begin
        if (lcnt == l2_lat) bus.l2_done = 1'b1;
        lcnt++;
      end
      lkind_prev = lkind;
    end
  end

  // Output monitor: grants, snoops, L2 accesses and completions.
  initial begin : monitor
    logic [N-1:0] gnt_prev = '0;
    logic [1:0]   lk_prev  = 2'b00;
    logic [1:0]   lk;
    int           g_cyc    = 0;
    bit           snoop_seen = 1'b0;
    txn_t         t;
    l2_t          a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gnt_prev = '0;
        lk_prev  = 2'b00;
        continue;
      end
      if (bus.gnt != '0 && gnt_prev == '0) begin
        g_cyc      = cyc;
        snoop_seen = 1'b0;
        if (b2b_check) check("rr_gap", cyc - last_done, 2);
        if (sb.size() == 0) check("gnt_unexpected", bus.gnt, 0);
        else                check("gnt_owner", bus.gnt, 1 << sb[0].src);
      end
      if (bus.snoop_valid && !snoop_seen) begin
        snoop_seen = 1'b1;
        if (sb.size() != 0) begin
          check("snoop_src", bus.snoop_src, sb[0].src);
          check("snoop_op", bus.snoop_op, sb[0].op);
          check("snoop_addr", bus.snoop_addr, sb[0].addr);
        end
      end
      lk = {bus.l2_rd_en, bus.l2_wr_en};
      if (lk != 2'b00 && lk != lk_prev) begin
        if (l2q.size() == 0) begin
          check("l2_unexpected", lk, 0);
        end else begin
          a = l2q.pop_front();
          check("l2_kind", lk, a.wr ? 2'b01 : 2'b10);
          check("l2_addr", bus.l2_addr, a.addr);
        end
      end
      lk_prev = lk;
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          check("done_unexpected", bus.done, 0);
        end else begin
          t = sb.pop_front();
          check("done_owner", bus.done, 1 << t.src);
          check("shared_out", bus.shared_out, t.shared);
          check("latency", cyc - g_cyc, t.lat);
          check("snooped", snoop_seen, (t.op != 3) ? 1 : 0);
          $display("txn src=%0d op=%0d addr=0x%0h shared=%0d latency=%0d",
                   t.src, t.op, t.addr, bus.shared_out, cyc - g_cyc);
        end
        last_done = cyc;
      end
      gnt_prev = bus.gnt;
    end
  end

  task automatic wait_done(input int n, input int budget);
    int got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clk);
      if (bus.done != '0) got++;
    end
    check("done_timeout", got, n);
  endtask

  task automatic set_req(input int src, input int op, input logic [AW-1:0] addr);
    bus.req_op[2*src +: 2]     = 2'(op);
    bus.req_addr[AW*src +: AW] = addr;
  endtask

  // Single request from idle: grant must appear on the next cycle.
  task automatic issue(input int src, input int op, input logic [AW-1:0] addr);
    expect_txn(src, op, addr);
    set_req(src, op, addr);
    bus.req[src] = 1'b1;
    @(negedge clk);
    check("gnt_latency", bus.gnt, 1 << src);
  endtask

  task automatic finish_txn(input int src, input int budget);
    wait_done(1, budget);
    bus.req[src] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    logic [63:0] va, vb;
    va = {46'd0, bus.gnt, bus.done, bus.shared_out, bus.snoop_valid, bus.snoop_op,
          bus.snoop_src, bus.l2_rd_en, bus.l2_wr_en, proto_err};
    vb = {bus.snoop_addr, bus.l2_addr};
    check({tag, "_ctl"}, va, 64'd0);
    check({tag, "_addr"}, vb, 64'd0);
  endtask

  initial begin : main
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_op   = '0;
    bus.req_addr = '0;
    cfg_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all requesters held, BusUpgr, immediate acks.
    for (int i = 0; i < N; i++) set_req(i, 2, AW'((i + 1) * 'h100));
    expect_txn(0, 2, 'h100);
    expect_txn(1, 2, 'h200);
    expect_txn(2, 2, 'h300);
    expect_txn(0, 2, 'h100);
    bus.req = 3'b111;
    @(negedge clk);
    check("rr_first_gnt", bus.gnt, 3'b001);
    wait_done(1, 50);
    b2b_check = 1'b1;
    wait_done(3, 100);
    bus.req   = '0;
    b2b_check = 1'b0;
    @(negedge clk);

    // BusRd with a late sharer and slow L2; request fields scrambled while granted.
    cfg_clear();
    ack_dly[1] = 3; shr[1] = 1'b1; l2_lat = 4;
    issue(0, 0, 'h40);
    bus.req_addr[AW*0 +: AW] = 'h0BAD;
    bus.req_op[1:0]          = 2'b11;
    finish_txn(0, 100);

    // BusRd with no sharers.
    cfg_clear();
    l2_lat = 4;
    issue(0, 0, 'h44);
    finish_txn(0, 100);

    // BusRdX hitting a Modified line in cache 0: flush then read.
    cfg_clear();
    drt[0] = 1'b1; shr[0] = 1'b1; l2_lat = 2;
    issue(2, 1, 'h80);
    finish_txn(2, 100);
    check("no_err_flush", proto_err, 1'b0);

    // WriteBack: no snoop, L2 write only.
    cfg_clear();
    l2_lat = 1;
    issue(1, 3, 'hC0);
    finish_txn(1, 100);

    // Stray l2_done during SNOOP must not move the FSM.
    cfg_clear();
    ack_dly[1] = 3; stray_en = 1'b1;
    issue(0, 0, 'h100);
    finish_txn(0, 100);
    stray_en = 1'b0;
    check("no_err_stray", proto_err, 1'b0);

    // BusUpgr with a dirty responder: error flagged, transaction completes.
    cfg_clear();
    drt[2] = 1'b1; shr[2] = 1'b1;
    issue(0, 2, 'h140);
    finish_txn(0, 100);
    check("proto_err_set", proto_err, 1'b1);
    cfg_clear();
    issue(1, 0, 'h180);
    finish_txn(1, 100);
    check("proto_err_sticky", proto_err, 1'b1);

    // Reset in the middle of a snoop aborts the transaction.
    cfg_clear();
    ack_dly[1] = 20;
    issue(2, 0, 'h1C0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_snoop");
    bus.req = '0;
    sb.delete();
    l2q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cfg_clear();
    repeat (5) @(negedge clk);
    check("idle_gnt", bus.gnt, 0);
    check("idle_done", bus.done, 0);

    // rr_ptr restarts at 0 after reset: requester 1 before requester 2.
    set_req(1, 2, 'h200);
    set_req(2, 2, 'h300);
    expect_txn(1, 2, 'h200);
    expect_txn(2, 2, 'h300);
    bus.req = 3'b110;
    @(negedge clk);
    check("rr_after_reset", bus.gnt, 3'b010);
    wait_done(1, 50);
    bus.req[1] = 1'b0;
    wait_done(1, 50);
    bus.req[2] = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    check("l2q_drained", l2q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
